// File: rtl/mult_pkg.sv
// Shared types for the shift-add multiplier controller and datapath.
package mult_pkg;
    localparam int WIDTH = 8;

    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic [1:0] {OP_HOLD, OP_ADD, OP_SUB} alu_op_t;

    // Sub wins when both strobes arrive together (an illegal controller output).
    function automatic alu_op_t decode_op(input logic add, input logic sub);
        if (sub)      return OP_SUB;
        else if (add) return OP_ADD;
        else          return OP_HOLD;
    endfunction
endpackage

// File: rtl/mult_datapath_if.sv
// Controller <-> datapath strobe and result bundle.
interface mult_datapath_if #(parameter int WIDTH = mult_pkg::WIDTH);
    logic [WIDTH-1:0] SW;
    logic             Shift;
    logic             Add;
    logic             Sub;
    logic             Clr;
    logic             LoadB;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             Xval;
    logic             M_val;

    modport master (output SW, Shift, Add, Sub, Clr, LoadB,
                    input  Aval, Bval, Xval, M_val);
    modport slave  (input  SW, Shift, Add, Sub, Clr, LoadB,
                    output Aval, Bval, Xval, M_val);
endinterface

// File: rtl/mult_datapath_add_sub9.sv
// Ripple-carry adder/subtractor; sub inverts b and injects the carry-in.
module add_sub9 #(
    parameter int W = mult_pkg::WIDTH + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);
    logic cy;
    logic bx;

    always_comb begin
        sum = '0;
        cy  = sub;
        bx  = 1'b0;
        for (int i = 0; i < W; i++) begin
            bx     = b[i] ^ sub;
            sum[i] = a[i] ^ bx ^ cy;
            cy     = (a[i] & bx) | (cy & (a[i] ^ bx));
        end
    end
endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: X/A/B/S registers and one add/sub-then-shift step per clock.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic            Clk,
    input  logic            Reset,
    mult_datapath_if.slave  bus
);
    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;

    alu_op_t          op;
    logic [WIDTH:0]   sum;
    logic             xn;
    logic [WIDTH-1:0] an;

    assign op = decode_op(bus.Add, bus.Sub);

    // Both operands are sign-extended so A - (-2^(W-1)) still fits.
    add_sub9 #(.W(WIDTH + 1)) u_add_sub (
        .a   ({a_q[WIDTH-1], a_q}),
        .b   ({s_q[WIDTH-1], s_q}),
        .sub (op == OP_SUB),
        .sum (sum)
    );

    always_comb begin
        xn = x_q;
        an = a_q;
        if (op != OP_HOLD) begin
            xn = sum[WIDTH];
            an = sum[WIDTH-1:0];
        end

        x_d = x_q;
        a_d = a_q;
        b_d = b_q;
        s_d = s_q;

        if (bus.Shift) begin
            x_d = xn;
            a_d = {xn, an[WIDTH-1:1]};
            b_d = {an[0], b_q[WIDTH-1:1]};
        end else if (op != OP_HOLD) begin
            x_d = xn;
            a_d = an;
        end

        if (bus.Clr) begin
            x_d = 1'b0;
            a_d = '0;
            s_d = bus.SW;
        end

        if (bus.LoadB) b_d = bus.SW;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
        end else begin
            x_q <= x_d;
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
        end
    end

    assign bus.Aval  = a_q;
    assign bus.Bval  = b_q;
    assign bus.Xval  = x_q;
    assign bus.M_val = b_q[0];
endmodule

// File: tb/tb_mult_datapath.sv
// Directed and randomized checks of mult_datapath against a signed-product reference.
module tb_mult_datapath;
    import mult_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   illegal_cnt = 0;
    word_t mdl_b;

    mult_datapath_if dif ();

    mult_datapath dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    // Flags the illegal Add+Sub controller combination.
    always @(posedge clk) if (dif.Add && dif.Sub) illegal_cnt <= illegal_cnt + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sh, input logic ad, input logic sb,
                         input logic cl, input logic lb, input word_t sw);
        dif.Shift = sh; dif.Add = ad; dif.Sub = sb;
        dif.Clr = cl;   dif.LoadB = lb; dif.SW = sw;
    endtask

    task automatic step(input logic sh, input logic ad, input logic sb,
                        input logic cl, input logic lb, input word_t sw);
        drive(sh, ad, sb, cl, lb, sw);
        @(negedge clk);
    endtask

    // Full 8-step multiply as the controller would sequence it.
    task automatic mult_run(input string tag, input word_t mcand, input logic do_loadb,
                            input word_t mplier);
        int    p;
        logic [15:0] pv;
        logic  m;
        if (do_loadb) step(0, 0, 0, 0, 1, mplier);
        step(0, 0, 0, 1, 0, mcand);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_mval"}, 16'(dif.M_val), 16'(mplier[i]));
            m = dif.M_val;
            step(1, (i < 7) ? m : 1'b0, (i == 7) ? m : 1'b0, 0, 0, 8'h00);
        end
        drive(0, 0, 0, 0, 0, 8'h00);
        p  = int'($signed(mcand)) * int'($signed(mplier));
        pv = p[15:0];
        chk({tag, "_prod"}, {dif.Aval, dif.Bval}, pv);
        chk({tag, "_x"}, 16'(dif.Xval), 16'(p < 0));
        mdl_b = pv[7:0];
    endtask

    initial begin
        word_t ra, rb;
        drive(0, 0, 0, 0, 0, 8'h00);
        mdl_b = 8'h00;

        @(negedge clk);
        chk("rst_a", 16'(dif.Aval), 16'h0);
        chk("rst_b", 16'(dif.Bval), 16'h0);
        chk("rst_x", 16'(dif.Xval), 16'h0);
        chk("rst_m", 16'(dif.M_val), 16'h0);
        rst = 1'b0;

        // Build A=0x35, B=0x12, then reset asynchronously mid-step.
        step(0, 0, 0, 1, 0, 8'h35);
        step(0, 1, 0, 0, 1, 8'h12);
        chk("pre_a", 16'(dif.Aval), 16'h35);
        chk("pre_b", 16'(dif.Bval), 16'h12);
        drive(1, 1, 0, 0, 0, 8'h00);
        #2 rst = 1'b1;
        #1;
        chk("arst_a", 16'(dif.Aval), 16'h0);
        chk("arst_b", 16'(dif.Bval), 16'h0);
        chk("arst_x", 16'(dif.Xval), 16'h0);
        chk("arst_m", 16'(dif.M_val), 16'h0);
        drive(0, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        mult_run("m7x-3", 8'h07, 1, 8'hFD);
        chk("m7x-3_lit", {dif.Aval, dif.Bval}, 16'hFFEB);
        mult_run("m128", 8'h80, 1, 8'h80);
        chk("m128_lit", {dif.Aval, dif.Bval}, 16'h4000);
        mult_run("m-1x1", 8'hFF, 1, 8'h01);
        chk("m-1x1_lit", {dif.Aval, dif.Bval}, 16'hFFFF);
        mult_run("chain", 8'h02, 0, mdl_b);
        chk("chain_lit", {dif.Aval, dif.Bval}, 16'hFFFE);

        // Strobe priority.
        step(0, 0, 0, 1, 0, 8'h10);
        step(0, 1, 0, 0, 1, 8'h06);
        chk("pr_seta", 16'(dif.Aval), 16'h10);
        step(1, 1, 0, 1, 0, 8'h33);
        chk("clr_a", 16'(dif.Aval), 16'h0);
        chk("clr_x", 16'(dif.Xval), 16'h0);
        chk("clr_b", 16'(dif.Bval), 16'h03);
        step(1, 0, 0, 0, 1, 8'h5A);
        chk("ldsh_b", 16'(dif.Bval), 16'h5A);
        chk("ldsh_a", 16'(dif.Aval), 16'h0);
        step(0, 1, 1, 0, 0, 8'h00);
        chk("addsub_a", 16'(dif.Aval), 16'hCD);
        chk("addsub_x", 16'(dif.Xval), 16'h1);
        chk("addsub_flag", 16'(illegal_cnt), 16'h1);

        // Shift-only step from A=0x81, X=1, B=0x02.
        step(0, 0, 0, 1, 0, 8'h81);
        step(0, 1, 0, 0, 1, 8'h02);
        chk("sh_pre_a", 16'(dif.Aval), 16'h81);
        chk("sh_pre_x", 16'(dif.Xval), 16'h1);
        step(1, 0, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 0, 0, 8'h00);
        chk("sh_a", 16'(dif.Aval), 16'hC0);
        chk("sh_b", 16'(dif.Bval), 16'h81);
        chk("sh_x", 16'(dif.Xval), 16'h1);
        chk("sh_m", 16'(dif.M_val), 16'h1);

        @(negedge clk);
        chk("hold_a", 16'(dif.Aval), 16'hC0);
        chk("hold_b", 16'(dif.Bval), 16'h81);

        // Random operands, alternating fresh multipliers with chained runs.
        for (int n = 0; n < 24; n++) begin
            ra = word_t'($urandom);
            rb = word_t'($urandom);
            if (n % 3 == 2) mult_run("rnd_chain", ra, 0, mdl_b);
            else            mult_run("rnd", ra, 1, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
